// File: rtl/hif_pkg.sv
// Shared types and helpers for the VGA host-cycle controller.
package hif_pkg;

    // Host-side handshake states.
    typedef enum logic [1:0] {
        H_IDLE,
        H_WAIT,
        H_BUS,
        H_ACK
    } host_state_t;

    // Target-bus engine states.
    typedef enum logic {
        B_IDLE,
        B_REQ
    } bus_state_t;

    // Field widths of the default configuration.
    localparam int HIF_AW = 23;
    localparam int HIF_DW = 32;
    localparam int HIF_NT = 4;

    // Posted-write FIFO entry. The top re-declares this layout with its own
    // parameter widths, because a package type cannot follow module parameters.
    typedef struct packed {
        logic [HIF_AW-1:0] addr;
        logic [HIF_DW-1:0] data;
        logic [HIF_NT-1:0] sel;
    } pw_entry_t;

    localparam int ONES_MAX = 256;

    // Fill pattern returned for timed-out or unclaimed reads.
    // The caller casts the result down to its own data width.
    function automatic logic [ONES_MAX-1:0] all_ones(input int w);
        logic [ONES_MAX-1:0] r;
        r = '0;
        for (int i = 0; i < ONES_MAX; i++) begin
            if (i < w) r[i] = 1'b1;
        end
        return r;
    endfunction

    // Width of the timeout counter. It must be able to hold TO_CYCLES.
    function automatic int cnt_w(input int to_cycles);
        return $clog2(to_cycles + 1);
    endfunction

endpackage

// File: rtl/hif_pw_fifo.sv
// Posted-write FIFO: synchronous, power-of-two depth, registered count.
module hif_pw_fifo #(
    parameter int W     = 59,
    parameter int DEPTH = 4
) (
    input  logic                     h_hclk,
    input  logic                     h_reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy update. Reset discards any queued entries.
    always_ff @(posedge h_hclk) begin
        if (h_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Storage write. The array has no reset; the pointers define validity.
    always_ff @(posedge h_hclk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/hif_cycle_ctl.sv
// Host-cycle controller: posts memory writes, orders non-posted cycles
// behind them, drives the one-hot target bus and times out silent targets.
module hif_cycle_ctl
    import hif_pkg::*;
#(
    parameter int DW        = 32,
    parameter int AW        = 23,
    parameter int NUM_TGT   = 4,
    parameter int PW_DEPTH  = 4,
    parameter int TO_CYCLES = 255
) (
    input  logic                   h_hclk,
    input  logic                   h_reset,
    input  logic                   t_svga_sel,
    input  logic                   t_mem_io_n,
    input  logic                   t_hrd_hwr_n,
    input  logic [AW-1:0]          t_haddr,
    input  logic [DW-1:0]          t_hdata_in,
    input  logic [NUM_TGT-1:0]     t_tgt_sel,
    input  logic [NUM_TGT-1:0]     tgt_ready_n,
    input  logic [NUM_TGT*DW-1:0]  tgt_rdata,
    output logic                   h_t_ready_n,
    output logic [DW-1:0]          t_hdata_out,
    output logic [NUM_TGT-1:0]     h_tgt_req,
    output logic [AW-1:0]          h_addr,
    output logic [DW-1:0]          h_wdata,
    output logic                   h_hrd_hwr_n,
    output logic                   h_mem_io_n,
    output logic                   h_timeout,
    output logic                   h_busy
);
    localparam int CW   = cnt_w(TO_CYCLES);
    localparam int CNTW = $clog2(PW_DEPTH) + 1;

    typedef struct packed {
        logic [AW-1:0]      addr;
        logic [DW-1:0]      data;
        logic [NUM_TGT-1:0] sel;
    } ent_t;

    host_state_t        h_state, h_next;
    bus_state_t         b_state, b_next;

    ent_t               push_ent, head_ent;
    logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CNTW-1:0]    fifo_count;

    logic [CW-1:0]      to_cnt;
    logic               src_host;     // current bus cycle belongs to the waiting host
    logic               no_tgt;       // current host cycle has no target to wait for

    logic               posted;
    logic [NUM_TGT-1:0] sel_1h;
    logic               host_start;
    logic               load_fifo, load_host;
    logic               tgt_hit, b_complete, b_expire, host_done;
    logic [DW-1:0]      rd_slice;

    assign posted   = t_mem_io_n && !t_hrd_hwr_n;
    // Lowest set bit of the decode wins.
    assign sel_1h   = t_tgt_sel & (~t_tgt_sel + NUM_TGT'(1));
    assign push_ent = '{addr: t_haddr, data: t_hdata_in, sel: sel_1h};

    // A non-posted cycle may only reach the bus once every posted write ahead
    // of it has drained and the engine is free.
    assign host_start = fifo_empty && (b_state == B_IDLE) &&
                        (((h_state == H_IDLE) && t_svga_sel && !posted) ||
                         (h_state == H_WAIT));

    assign tgt_hit    = |(h_tgt_req & ~tgt_ready_n);
    assign b_complete = (b_state == B_REQ) && (no_tgt || tgt_hit);
    assign b_expire   = (b_state == B_REQ) && !no_tgt && !tgt_hit &&
                        (to_cnt == CW'(TO_CYCLES - 1));
    assign host_done  = (b_complete || b_expire) && src_host;
    assign fifo_pop   = (b_complete || b_expire) && !src_host;

    assign h_t_ready_n = (h_state != H_ACK);
    assign h_busy      = (fifo_count != '0) || (b_state == B_REQ);

    hif_pw_fifo #(
        .W     ($bits(ent_t)),
        .DEPTH (PW_DEPTH)
    ) u_pw_fifo (
        .h_hclk  (h_hclk),
        .h_reset (h_reset),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wdata   (push_ent),
        .rdata   (head_ent),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Read data of whichever target is currently requested.
    always_comb begin
        rd_slice = '0;
        for (int i = 0; i < NUM_TGT; i++) begin
            if (h_tgt_req[i]) rd_slice = rd_slice | tgt_rdata[i*DW +: DW];
        end
    end

    // State registers for both FSMs.
    always_ff @(posedge h_hclk) begin
        if (h_reset) begin
            h_state <= H_IDLE;
            b_state <= B_IDLE;
        end else begin
            h_state <= h_next;
            b_state <= b_next;
        end
    end

    // Host FSM: accept posted writes into the FIFO, hand others to the bus.
    always_comb begin
        h_next    = h_state;
        fifo_push = 1'b0;
        case (h_state)
            H_IDLE: begin
                if (t_svga_sel) begin
                    if (posted) begin
                        if (t_tgt_sel == '0) begin
                            h_next = H_ACK;            // unclaimed write is dropped
                        end else if (!fifo_full) begin
                            fifo_push = 1'b1;
                            h_next    = H_ACK;
                        end
                    end else begin
                        h_next = host_start ? H_BUS : H_WAIT;
                    end
                end
            end
            H_WAIT:  if (host_start) h_next = H_BUS;
            H_BUS:   if (host_done) h_next = H_ACK;
            H_ACK:   h_next = H_IDLE;
            default: h_next = H_IDLE;
        endcase
    end

    // Bus engine FSM: FIFO head first, host cycle only when the FIFO is empty.
    always_comb begin
        b_next    = b_state;
        load_fifo = 1'b0;
        load_host = 1'b0;
        case (b_state)
            B_IDLE: begin
                if (!fifo_empty) begin
                    load_fifo = 1'b1;
                    b_next    = B_REQ;
                end else if (host_start) begin
                    load_host = 1'b1;
                    b_next    = B_REQ;
                end
            end
            B_REQ:   if (b_complete || b_expire) b_next = B_IDLE;
            default: b_next = B_IDLE;
        endcase
    end

    // Target-bus outputs and timeout counter; held stable for the whole B_REQ.
    always_ff @(posedge h_hclk) begin
        if (h_reset) begin
            h_tgt_req   <= '0;
            h_addr      <= '0;
            h_wdata     <= '0;
            h_hrd_hwr_n <= 1'b1;
            h_mem_io_n  <= 1'b0;
            src_host    <= 1'b0;
            no_tgt      <= 1'b0;
            to_cnt      <= '0;
        end else if (load_fifo) begin
            h_tgt_req   <= head_ent.sel;
            h_addr      <= head_ent.addr;
            h_wdata     <= head_ent.data;
            h_hrd_hwr_n <= 1'b0;
            h_mem_io_n  <= 1'b1;
            src_host    <= 1'b0;
            no_tgt      <= 1'b0;
            to_cnt      <= '0;
        end else if (load_host) begin
            h_tgt_req   <= sel_1h;
            h_addr      <= t_haddr;
            h_wdata     <= t_hdata_in;
            h_hrd_hwr_n <= t_hrd_hwr_n;
            h_mem_io_n  <= t_mem_io_n;
            src_host    <= 1'b1;
            no_tgt      <= (t_tgt_sel == '0);
            to_cnt      <= '0;
        end else if (b_state == B_REQ) begin
            if (b_complete || b_expire) begin
                h_tgt_req <= '0;
                no_tgt    <= 1'b0;
                to_cnt    <= '0;
            end else begin
                to_cnt    <= to_cnt + CW'(1);
            end
        end
    end

    // Read return register and timeout pulse.
    always_ff @(posedge h_hclk) begin
        if (h_reset) begin
            t_hdata_out <= '0;
            h_timeout   <= 1'b0;
        end else begin
            h_timeout <= b_expire;
            if (host_done && h_hrd_hwr_n) begin
                t_hdata_out <= tgt_hit ? rd_slice : DW'(all_ones(DW));
            end
        end
    end

endmodule

// File: doc/hif_cycle_ctl.md
# hif_cycle_ctl

Parametrised host-cycle controller for the VGA host interface. It sits between the host-side address decode and the VGA target modules (attribute, CRTC, graphics, memory, and any extension targets). It generalises the fixed four-target ready handshake to NUM_TGT targets with configurable widths. It adds a posted-write buffer for memory writes, strict ordering of non-posted cycles behind buffered writes, and a per-cycle target timeout.

## Interface
Parameters:
- DW, 32, host/target data width
- AW, 23, host address width
- NUM_TGT, 4, number of target modules
- PW_DEPTH, 4, posted-write FIFO entries (power of two, ≥2)
- TO_CYCLES, 255, target timeout in h_hclk cycles (≥2)

Ports:
- h_hclk  in  1  clock; single clock domain
- h_reset  in  1  synchronous, active-high reset
- t_svga_sel  in  1  host cycle request, held until acknowledged
- t_mem_io_n  in  1  1 = memory, 0 = IO
- t_hrd_hwr_n  in  1  1 = read, 0 = write
- t_haddr  in  AW  host address
- t_hdata_in  in  DW  host write data
- t_tgt_sel  in  NUM_TGT  target decode; lowest set bit wins; zero = no target
- tgt_ready_n  in  NUM_TGT  per-target completion, active low
- tgt_rdata  in  NUM_TGT*DW  per-target read data, slice i = target i
- h_t_ready_n  out  1  host acknowledge, active low, one-cycle pulse
- t_hdata_out  out  DW  registered read data
- h_tgt_req  out  NUM_TGT  one-hot target request, held until completion or timeout
- h_addr / h_wdata  out  AW / DW  target-bus address and write data
- h_hrd_hwr_n, h_mem_io_n  out  1  target-bus cycle type
- h_timeout  out  1  one-cycle pulse on target timeout
- h_busy  out  1  FIFO non-empty or target-bus cycle active

## Operation
- Posted: memory write (t_mem_io_n=1, t_hrd_hwr_n=0). All other cycles are non-posted.
- Host FSM states:
  - H_IDLE samples t_svga_sel.
  - Posted write with FIFO not full → push {addr, data, sel} → H_ACK.
  - Posted write with FIFO full → stay in H_IDLE and re-sample each cycle. Full is evaluated on the registered count; a same-cycle pop does not free a slot.
  - Non-posted → H_WAIT until FIFO is empty and the bus is idle → H_BUS.
  - H_BUS waits for the bus engine to finish → H_ACK.
  - H_ACK drives h_t_ready_n=0 for one cycle → H_IDLE.
- Bus engine states B_IDLE / B_REQ:
  - FIFO head has priority. The host non-posted cycle starts only when the FIFO is empty.
  - B_REQ holds h_tgt_req, h_addr, h_wdata and type stable.
  - Completion: tgt_ready_n[i]=0 while h_tgt_req[i]=1. On a read, tgt_rdata slice i is captured into t_hdata_out in the same cycle.
  - A FIFO entry pops on completion.
- Timeout: the counter starts at 0 on entry to B_REQ.
  - At TO_CYCLES with no completion: drop h_tgt_req, pulse h_timeout, return to B_IDLE.
  - A timed-out read returns all ones.
  - A timed-out posted write is popped and discarded.
- No target (t_tgt_sel=0):
  - Non-posted → no h_tgt_req; completes in one bus cycle; a read returns all ones.
  - Posted → acknowledged and dropped; never enters the FIFO.
- t_hdata_out holds its value until the next read completion.
- Reset mid-operation: FIFO emptied (pending writes lost), both FSMs to idle, counter cleared.
- Reset values: h_t_ready_n=1, h_tgt_req=0, h_timeout=0, h_busy=0, t_hdata_out=0, h_addr=0, h_wdata=0, h_hrd_hwr_n=1, h_mem_io_n=0.

## Timing
- Request sampled in cycle 0 (H_IDLE):
  - Posted write: h_t_ready_n low in cycle 1.
  - Non-posted, FIFO empty: h_tgt_req high in cycle 1.
- Target completion in cycle n → h_t_ready_n low and t_hdata_out valid in cycle n+1.
- Minimum non-posted latency is 3 cycles (request, one-cycle target, ack).
- FIFO drain: the next entry is requested the cycle after the previous completion, so there is one B_IDLE bubble between entries.
- The host must change or deassert t_svga_sel in the cycle after h_t_ready_n=0. H_IDLE samples again in that cycle.
- Timeout fires in cycle TO_CYCLES after the request rises. h_timeout and the h_tgt_req drop occur in the same cycle.

## Structure
- Package hif_pkg holds:
  - host and bus state enums
  - ALL_ONES fill constant function
  - FIFO entry struct {addr, data, sel}
  - counter width as $clog2(TO_CYCLES+1)
- Sub-module hif_pw_fifo: synchronous FIFO, PW_DEPTH × (AW+DW+NUM_TGT), with full/empty/count. Reset clears the pointers.

## Test plan
- Reset mid-drain, 2 entries queued → all outputs at reset values the cycle after h_reset; h_busy=0; no further h_tgt_req.
- IO read, t_tgt_sel=4'b0010, target 1 drives ready_n low 3 cycles after the request with rdata 0x0000_00A5 → t_hdata_out=0x0000_00A5 and a single h_t_ready_n pulse in the following cycle.
- 5 back-to-back memory writes to target 0, which stalls 10 cycles per write → writes 1–4 each acknowledged one cycle after sampling; write 5 is held until the first completion and accepted the cycle after.
- IO read to target 2 issued behind 3 queued writes to target 0 → h_tgt_req[2] rises only after the third write pops. Target-bus order is W, W, W, R.
- Target 3 never responds to a read, TO_CYCLES=255 → h_timeout pulse at cycle 255; t_hdata_out=0xFFFF_FFFF; host acknowledged; next cycle is serviced normally.
- Read with t_tgt_sel=0 → 0xFFFF_FFFF with no h_tgt_req. Read with t_tgt_sel=4'b1010 → only h_tgt_req[1] asserted.
